serial_add_ctrl: RTL and testbench

- Bit-serial addition sequencer. It shares one external 1-bit full-adder cell across all bit positions of a WIDTH-bit add.
- Takes a start request with operands and presents one LSB-first bit pair per cycle to the full-adder.
- Recirculates the carry and assembles the result in a shift register.
- Sits between a requester (testbench or top-level control) and the 1-bit adder cell. This trades area for WIDTH cycles of latency.

---
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer driving one shared external 1-bit full-adder cell, LSB first.
// Optional SERIAL_ADD_SUB_EN adds a subtract mode (sub) and a signed-overflow flag (ovf).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [WIDTH-1:0] res_next;

    // Subtraction is A + ~B + 1, so only the B operand and the initial carry change.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load = sub ? ~b_in : b_in;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b_in;
    assign c_load = cin;
`endif

    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign res_next = {fa_sum, res_sh[WIDTH-1:1]};

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign fa_a   = busy & a_sh[0];
    assign fa_b   = busy & b_sh[0];
    assign fa_cin = busy & c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a_in;
                        b_sh   <= b_load;
                        c      <= c_load;
                        cnt    <= '0;
                        res_sh <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    c      <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Results are captured on the final bit so they appear together with done.
                    if (last) begin
                        sum_out <= res_next;
                        cout    <= fa_cout;
`ifdef SERIAL_ADD_SUB_EN
                        ovf     <= c ^ fa_cout;
`endif
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl; the bench also models the 1-bit adder cell.
// Define SERIAL_ADD_SUB_EN to exercise the subtract mode and overflow flag as well.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         sub;
    logic         ovf;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic [1:0]   fa_res;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External full-adder cell
    assign fa_res  = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_cin};
    assign fa_sum  = fa_res[0];
    assign fa_cout = fa_res[1];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub),
        .ovf     (ovf),
`endif
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

`ifndef SERIAL_ADD_SUB_EN
    assign ovf = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one operation from IDLE; called on a negedge, returns on the negedge after DONE.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic s);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        logic         ovf_exp;
        logic [W-1:0] a_bits;
        logic [W-1:0] b_bits;
        int n;
        int nb;
        be      = s ? ~b : b;
        ce      = s ? 1'b1 : ci;
        full    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
        ovf_exp = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        a_bits  = '0;
        b_bits  = '0;
        n  = 0;
        nb = 0;
        a_in  = a;
        b_in  = b;
        cin   = ci;
        sub   = s;
        start = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (done) break;
            if (busy) begin
                if (nb < W) begin
                    a_bits[nb] = fa_a;
                    b_bits[nb] = fa_b;
                end
                nb++;
            end
        end
        chk({tag, "_latency"}, n, W + 1);
        chk({tag, "_busy_cycles"}, nb, W);
        chk({tag, "_fa_a_bits"}, a_bits, a);
        chk({tag, "_fa_b_bits"}, b_bits, be);
        chk({tag, "_sum"}, sum_out, full[W-1:0]);
        chk({tag, "_cout"}, cout, full[W]);
`ifdef SERIAL_ADD_SUB_EN
        chk({tag, "_ovf"}, ovf, ovf_exp);
`endif
        @(negedge clk);
        chk({tag, "_done_single"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int i;
        int ndone;
        int last_done;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum_out, '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_fa", {fa_a, fa_b, fa_cin}, 3'b000);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        do_op("d5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op("dff01", 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op("dff00c", 8'hFF, 8'h00, 1'b1, 1'b0);
        do_op("d0000", 8'h00, 8'h00, 1'b0, 1'b0);

        // Start held high: one accepted op every W+2 cycles, operands scrambled while busy.
        a_in  = 8'h01;
        b_in  = 8'h01;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        ndone = 0;
        last_done = -1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("b2b_sum", sum_out, 8'h02);
                chk("b2b_cout", cout, 1'b0);
                if (last_done >= 0) chk("b2b_period", k - last_done, W + 2);
                last_done = k;
            end
            if (busy) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
            end else begin
                a_in = 8'h01;
                b_in = 8'h01;
            end
        end
        chk("b2b_count", ndone, 3);
        start = 1'b0;
        a_in  = 8'h01;
        b_in  = 8'h01;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while ((busy || done) && i < 20);
        chk("b2b_drain", busy | done, 1'b0);

        // Reset mid-operation abandons the add with no done pulse.
        a_in  = 8'h12;
        b_in  = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_sum", sum_out, '0);
        chk("midrst_cout", cout, 1'b0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        do_op("d1234", 8'h12, 8'h34, 1'b0, 1'b0);

        // Reset and start together: nothing begins.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("rststart_busy", busy, 1'b0);
        chk("rststart_sum", sum_out, '0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rststart_busy2", busy, 1'b0);
        chk("rststart_done2", done, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        do_op("s1001", 8'h10, 8'h01, 1'b1, 1'b1);
        do_op("s8001", 8'h80, 8'h01, 1'b0, 1'b1);
        do_op("a7f01", 8'h7F, 8'h01, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 30; k++) begin
            logic s;
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            do_op("rnd", W'($urandom), W'($urandom), 1'($urandom), s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
